// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM state and operation select.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Single combinational full-adder cell; the whole serial datapath reuses this one bit slice.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// with valid/ready handshakes on operands and on the result.
module serial_add_sub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_s;
  logic             sum_s;
  logic             co_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (cnt_r == LAST_CNT);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  fa_cell u_fa (
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .ci (carry_r),
    .s  (sum_s),
    .co (co_s)
  );

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; out_valid is registered from the next-state so it is high exactly in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand shifters, carry flop, bit counter and result/flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
            a_sh_r   <= a;
            b_sh_r   <= (sub == OP_SUB) ? ~b : b;
            carry_r  <= sub;
            cnt_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
          end else begin
            a_sh_r <= a_sh_r;
          end
        end
        ST_RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          result_r <= {sum_s, result_r[WIDTH-1:1]};
          carry_r  <= co_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            // carry_r here is the carry into the MSB.
            cout_r <= co_s;
            ovf_r  <= carry_r ^ co_s;
          end else begin
            cout_r <= cout_r;
          end
        end
        ST_DONE: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule
